dcollide_spheres_fx: RTL
========================

# dcollide_spheres_fx

Parametrised fixed-point sphere–sphere collision engine. It is the successor of the floating-point `dCollideSpheres` path. It accepts one sphere pair per transaction over a valid/ready handshake and computes `ret`, contact position, unit normal and penetration depth in signed Q(W−F).F. Internally it uses squared-distance early rejection, an iterative integer square root and three parallel iterative dividers. It sits between the broad-phase pair FIFO and the contact writer, and passes a user tag through unchanged.

## Interface
- `W`, 32, total signed fixed-point width of every coordinate/radius/result.
- `F`, 16, fractional bits; F < W−2.
- `TAGW`, 32, width of pass-through tag (geom IDs).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  pair valid.
- `in_ready`  out  1  high only in IDLE.
- `x1,y1,z1,r1,x2,y2,z2,r2`  in  W each  sphere centres/radii, signed Q format; radii ≥ 0.
- `detect_only`  in  1  sampled with pair; 1 = compute `ret` only.
- `tag_in`  in  TAGW  carried to `tag_out`.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts when high with `out_valid`.
- `ret`  out  1  1 = spheres touch or overlap.
- `cx,cy,cz`  out  W each  contact position.
- `nx,ny,nz`  out  W each  unit normal, pointing from sphere 2 toward sphere 1.
- `depth`  out  W  penetration depth.
- `tag_out`  out  TAGW  tag of this result.

## Operation
- States: IDLE, DIFF, SQUARE, CMP, SQRT, DIV, POS, OUT.
- IDLE: `in_ready`=1; on `in_valid`: register inputs, `detect_only` and tag, then go to DIFF.
- DIFF: dx=x1−x2, dy, dz (W+1 bits), rs=r1+r2 (W+1 bits), rd=r2−r1.
- SQUARE: d2=dx²+dy²+dz² (2W+4 bits, 2F frac); rs2=rs².
- CMP, evaluated in priority order:
  - d2 > rs2: ret=0, all data outputs 0, go to OUT.
  - otherwise, if detect_only: ret=1, data outputs 0, go to OUT.
  - otherwise, if d2 == 0 (coincident): ret=1, pos=(x1,y1,z1), n=(1.0,0,0) i.e. 1<<F, depth=rs truncated to W, go to OUT.
  - otherwise go to SQRT.
- Contact is inclusive: d == r1+r2 collides with depth 0.
- SQRT: restoring integer sqrt of d2, 2 bits per iteration, W+2 cycles. d=floor(√d2) has F frac bits and is always > 0.
- DIV: three restoring dividers in parallel, each computing n?=(d? << F)/d on magnitudes with sign restored after. Quotient |n?| ≤ 1<<F; F+2 cycles; truncation toward zero.
- POS: depth=rs−d; k=(rd−d)>>>1 (arithmetic shift); c?=p1?+((n?·k)>>>F).
- All results are truncated to W bits, wrapping with no saturation. Callers keep |coords| < 2^(W−3) in Q units so that no wrap occurs.
- OUT: `out_valid`=1 and all outputs stable; on `out_ready`, go to IDLE.
- Outputs are registered and change only on entry to OUT or on reset.

## Timing
- Reset: state IDLE; `in_ready`=1 after reset deasserts. `out_valid`, `ret`, all position/normal/depth outputs and `tag_out` are 0.
- `rst` in any state aborts the transaction; the pair is discarded and no result is produced.
- Acceptance edge E0. `out_valid` goes high after:
  - E3 for non-colliding, detect_only or coincident pairs;
  - E(W+F+8) for full contact; 56 cycles at W=32, F=16.
- Throughput: one pair in flight. The OUT→IDLE transition costs one cycle, so `in_ready` rises the cycle after the output handshake. There is no same-cycle in/out overlap.
- `out_ready` held low: OUT persists indefinitely with outputs unchanged.
- `in_valid` outside IDLE is ignored; inputs need not be held after acceptance.

## Test plan
- p1=(0,0,0), r1=1.0; p2=(3.0,0,0), r2=1.0 (Q16.16) -> ret=0, all data outputs 0, `out_valid` at E3.
- p1=(0,0,0), r1=r2=1.0, p2=(1.5,0,0) -> ret=1, n=(0xFFFF0000,0,0), depth=0x00008000, c=(0x0000C000,0,0), `out_valid` at E56. Also re-run at W=24, F=10 and check latency 42.
- p2=(2.0,0,0), radii 1.0 -> ret=1, depth=0, c=(0x00010000,0,0); p2=(0,0,0) -> ret=1, n=(0x00010000,0,0), depth=0x00020000, c=p1, latency 3.
- Diagonal p2=(1.0,1.0,1.0), radii 1.0 -> ret=1; n=(−0.57735,−0.57735,−0.57735) within 2 LSB; depth=2−√3 within 2 LSB. Same pair with detect_only=1 -> ret=1, data outputs 0, latency 3.
- Hold `out_ready` low for 20 cycles -> outputs stable, `in_ready`=0, extra `in_valid` ignored. Then assert `out_ready` -> `in_ready` high the next cycle, and `tag_out` equals `tag_in` of the accepted pair.
- Assert `rst` for 1 cycle in SQRT -> next cycle IDLE, all outputs 0, no `out_valid`. A new pair is then processed correctly.

Source files
------------

// File: rtl/dcollide_spheres_fx.sv
// rtl/dcollide_spheres_fx.sv - fixed-point sphere/sphere collision engine
// Squared-distance rejection, iterative sqrt, three parallel dividers, contact geometry.
module dcollide_spheres_fx #(
  parameter int W    = 32,
  parameter int F    = 16,
  parameter int TAGW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    x1,
  input  logic [W-1:0]    y1,
  input  logic [W-1:0]    z1,
  input  logic [W-1:0]    r1,
  input  logic [W-1:0]    x2,
  input  logic [W-1:0]    y2,
  input  logic [W-1:0]    z2,
  input  logic [W-1:0]    r2,
  input  logic            detect_only,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ret,
  output logic [W-1:0]    cx,
  output logic [W-1:0]    cy,
  output logic [W-1:0]    cz,
  output logic [W-1:0]    nx,
  output logic [W-1:0]    ny,
  output logic [W-1:0]    nz,
  output logic [W-1:0]    depth,
  output logic [TAGW-1:0] tag_out
);

  localparam int DW = 2*W + 4;   // squared-distance width
  localparam int RW = W + 6;     // sqrt partial remainder
  localparam int VW = W + 3;     // divider partial remainder
  localparam int QW = F + 2;     // quotient bits
  localparam int PW = 2*W + 3;   // normal * k product
  localparam int CW = $clog2(W + 2) + 1;

  typedef enum logic [2:0] {
    IDLE, DIFF, SQUARE, CMP, SQRT, DIV, POS, OUT
  } state_t;

  state_t state, state_nx;

  logic [2:0][W-1:0]  p1, p2;
  logic [W-1:0]       ra, rb;
  logic               det;
  logic [TAGW-1:0]    tag;
  logic [2:0][W:0]    dd;
  logic [W:0]         rs, rd;
  logic [DW-1:0]      d2, rs2, sq_rad;
  logic [RW-1:0]      sq_rem;
  logic [W+1:0]       root;
  logic [2:0][VW-1:0] dv_rem;
  logic [2:0][QW-1:0] dv_lo, dv_q;
  logic [CW-1:0]      cnt;

  logic [2:0][W-1:0]  n_r, c_r;

  logic               far, coinc;
  logic signed [DW-1:0] sx [3];
  logic [2:0][DW-1:0] sq;
  logic signed [DW-1:0] rse;
  logic [DW-1:0]      rs2_c;
  logic [RW-1:0]      rem_sh, trial;
  logic               sq_ge;
  logic [2:0][W:0]    absd;
  logic [2:0][VW-1:0] dv_sh;
  logic [2:0]         dv_ge;
  logic [2:0][W-1:0]  nq;
  logic signed [W-1:0]  nv [3];
  logic signed [VW-1:0] dep, kv;
  logic signed [PW-1:0] prod [3];
  logic signed [PW-1:0] psh [3];
  logic [2:0][W-1:0]  cv;

  assign in_ready = (state == IDLE);
  assign far      = d2 > rs2;
  assign coinc    = (d2 == '0);

  assign cx = c_r[0];
  assign cy = c_r[1];
  assign cz = c_r[2];
  assign nx = n_r[0];
  assign ny = n_r[1];
  assign nz = n_r[2];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = DIFF;
      DIFF:    state_nx = SQUARE;
      SQUARE:  state_nx = CMP;
      CMP:     state_nx = (far || det || coinc) ? OUT : SQRT;
      SQRT:    if (cnt == '0) state_nx = DIV;
      DIV:     if (cnt == '0) state_nx = POS;
      POS:     state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rse    = '0;
    rs2_c  = '0;
    rem_sh = '0;
    trial  = '0;
    sq_ge  = 1'b0;
    dep    = '0;
    kv     = '0;
    sq     = '0;
    absd   = '0;
    dv_sh  = '0;
    dv_ge  = '0;
    nq     = '0;
    cv     = '0;
    for (int i = 0; i < 3; i++) begin
      sx[i]   = '0;
      nv[i]   = '0;
      prod[i] = '0;
      psh[i]  = '0;
    end

    rse   = $signed({{3{rs[W]}}, rs});
    rs2_c = rse * rse;

    // Restoring sqrt: two radicand bits enter per step, one root bit leaves.
    rem_sh = {sq_rem[RW-3:0], sq_rad[DW-1 -: 2]};
    trial  = {2'b00, root, 2'b01};
    sq_ge  = rem_sh >= trial;

    dep = $signed({{2{rs[W]}}, rs}) - $signed({1'b0, root});
    kv  = ($signed({{2{rd[W]}}, rd}) - $signed({1'b0, root})) >>> 1;

    for (int i = 0; i < 3; i++) begin
      sx[i]    = $signed({{3{dd[i][W]}}, dd[i]});
      sq[i]    = sx[i] * sx[i];
      absd[i]  = dd[i][W] ? -dd[i] : dd[i];
      dv_sh[i] = {dv_rem[i][VW-2:0], dv_lo[i][QW-1]};
      dv_ge[i] = dv_sh[i] >= {1'b0, root};
      nq[i]    = {{(W-QW){1'b0}}, dv_q[i]};
      nv[i]    = dd[i][W] ? -$signed(nq[i]) : $signed(nq[i]);
      prod[i]  = $signed({{(W+3){nv[i][W-1]}}, nv[i]}) * $signed({{W{kv[VW-1]}}, kv});
      psh[i]   = prod[i] >>> F;
      cv[i]    = p1[i] + psh[i][W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        p1  <= {z1, y1, x1};
        p2  <= {z2, y2, x2};
        ra  <= r1;
        rb  <= r2;
        det <= detect_only;
        tag <= tag_in;
      end
      DIFF: begin
        for (int i = 0; i < 3; i++)
          dd[i] <= {p1[i][W-1], p1[i]} - {p2[i][W-1], p2[i]};
        rs <= {ra[W-1], ra} + {rb[W-1], rb};
        rd <= {rb[W-1], rb} - {ra[W-1], ra};
      end
      SQUARE: begin
        d2  <= sq[0] + sq[1] + sq[2];
        rs2 <= rs2_c;
      end
      CMP: begin
        sq_rad <= d2;
        sq_rem <= '0;
        root   <= '0;
        cnt    <= CW'(W + 1);
      end
      SQRT: begin
        sq_rad <= sq_rad << 2;
        sq_rem <= sq_ge ? rem_sh - trial : rem_sh;
        root   <= {root[W:0], sq_ge};
        cnt    <= (cnt == '0) ? CW'(F + 1) : cnt - 1'b1;
        // Dividend top bits seed the remainder; |d?| <= d keeps it below the divisor.
        for (int i = 0; i < 3; i++) begin
          dv_rem[i] <= {4'b0000, absd[i][W:2]};
          dv_lo[i]  <= {absd[i][1:0], {F{1'b0}}};
          dv_q[i]   <= '0;
        end
      end
      DIV: begin
        cnt <= cnt - 1'b1;
        for (int i = 0; i < 3; i++) begin
          dv_rem[i] <= dv_ge[i] ? dv_sh[i] - {1'b0, root} : dv_sh[i];
          dv_lo[i]  <= dv_lo[i] << 1;
          dv_q[i]   <= {dv_q[i][QW-2:0], dv_ge[i]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ret       <= 1'b0;
      n_r       <= '0;
      c_r       <= '0;
      depth     <= '0;
      tag_out   <= '0;
    end else begin
      case (state)
        CMP: if (far || det || coinc) begin
          out_valid <= 1'b1;
          tag_out   <= tag;
          ret       <= !far;
          if (!far && !det) begin
            n_r[0] <= {{(W-F-1){1'b0}}, 1'b1, {F{1'b0}}};
            n_r[1] <= '0;
            n_r[2] <= '0;
            c_r    <= p1;
            depth  <= rs[W-1:0];
          end else begin
            n_r   <= '0;
            c_r   <= '0;
            depth <= '0;
          end
        end
        POS: begin
          out_valid <= 1'b1;
          tag_out   <= tag;
          ret       <= 1'b1;
          for (int i = 0; i < 3; i++) n_r[i] <= nv[i];
          c_r   <= cv;
          depth <= dep[W-1:0];
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
